// File: rtl/predictor_pkg.sv
// Shared decode helpers for the gshare predictor: RV32 opcodes, immediate
// extraction and the saturating-counter step.
package predictor_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Counters up to 8 bits wide; max is the saturation ceiling.
    function automatic logic [7:0] ctr_next(input logic [7:0] ctr, input logic [7:0] max,
                                            input logic inc);
        if (inc)
            return (ctr == max) ? ctr : ctr + 8'd1;
        return (ctr == 8'd0) ? ctr : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/pred_btb.sv
// Direct-mapped branch target buffer for JALR: one read port for fetch,
// one write port for commit.
module pred_btb #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic [ADDR_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic [ADDR_W-1:0] wr_target
);
    localparam int N     = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid  [N];
    logic [TAG_W-1:0]  tag    [N];
    logic [ADDR_W-1:0] target [N];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    assign rd_idx = rd_pc[IDX_W+1:2];
    assign wr_idx = wr_pc[IDX_W+1:2];

    assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_pc[ADDR_W-1:IDX_W+2]);
    assign rd_target = target[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) valid[i] <= 1'b0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag[wr_idx]    <= wr_pc[ADDR_W-1:IDX_W+2];
            target[wr_idx] <= wr_target;
        end
    end

    logic unused_pc;
    assign unused_pc = ^{rd_pc[1:0], wr_pc[1:0]};

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor with speculative history and commit-time repair.
// Define PREDICTOR_BTB_EN to add a JALR target buffer (pred_btb).
module branch_predictor_gshare
    import predictor_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter int PHT_IDX_W = 8,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              rob_valid,
    input  logic              rob_is_jalr,
    input  logic [ADDR_W-1:0] rob_pc,
    input  logic              rob_taken,
    input  logic [ADDR_W-1:0] rob_target,
    input  logic [GHR_W-1:0]  rob_ghr,
    input  logic              rob_mispredict
);
    localparam int               PHT_N    = 2 ** PHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    logic [CTR_W-1:0]     pht [PHT_N];
    logic [GHR_W-1:0]     ghr;
    logic [PHT_IDX_W-1:0] idx, train_idx;
    logic [CTR_W-1:0]     pht_rd;
    logic [6:0]           opcode;
    logic [ADDR_W-1:0]    pc_seq, tgt_j, tgt_b;
    logic                 btb_hit;
    logic [ADDR_W-1:0]    btb_target;

    assign idx       = if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign train_idx = rob_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(rob_ghr);
    assign pht_rd    = pht[idx];
    assign opcode    = if_inst[6:0];
    assign pred_ghr  = ghr;

    assign pc_seq = if_pc + ADDR_W'(4);
    assign tgt_j  = if_pc + ADDR_W'(signed'(imm_j(if_inst[31:0])));
    assign tgt_b  = if_pc + ADDR_W'(signed'(imm_b(if_inst[31:0])));

`ifdef PREDICTOR_BTB_EN
    pred_btb #(.ADDR_W(ADDR_W), .IDX_W(BTB_IDX_W)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (if_pc),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (rdy && rob_valid && rob_is_jalr),
        .wr_pc     (rob_pc),
        .wr_target (rob_target)
    );
`else
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_seq;
        if (if_valid) begin
            case (opcode)
                OP_JAL: begin
                    pred_taken  = 1'b1;
                    pred_target = tgt_j;
                end
                OP_BRANCH: if (pht_rd[CTR_W-1]) begin
                    pred_taken  = 1'b1;
                    pred_target = tgt_b;
                end
                OP_JALR: if (btb_hit) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_target;
                end
                default: ;
            endcase
        end
    end

    // Commit-time repair wins over the speculative shift from fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (rdy) begin
            if (rob_valid && rob_mispredict)
                ghr <= rob_is_jalr ? rob_ghr : GHR_W'({rob_ghr, rob_taken});
            else if (if_valid && opcode == OP_BRANCH)
                ghr <= GHR_W'({ghr, pred_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
        end else if (rdy && rob_valid && !rob_is_jalr) begin
            pht[train_idx] <= CTR_W'(ctr_next(8'(pht[train_idx]), 8'(CTR_MAX), rob_taken));
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_inst, if_pc, rob_pc, rob_target, btb_target};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare: directed vector table,
// hand sequences for multi-cycle corners, then random traffic vs a model.
module tb_branch_predictor_gshare;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        rob_valid, rob_is_jalr, rob_taken, rob_mispredict;
    logic [31:0] rob_pc, rob_target;
    logic [7:0]  rob_ghr;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .rob_valid(rob_valid), .rob_is_jalr(rob_is_jalr), .rob_pc(rob_pc),
        .rob_taken(rob_taken), .rob_target(rob_target), .rob_ghr(rob_ghr),
        .rob_mispredict(rob_mispredict)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: counters as plain integers 0..3, history as an integer.
    int mpht[256];
    int mghr;
    bit          mbv[16];
    logic [31:0] mbpc[16], mbtgt[16];

    // Fetch description kept at the abstract level: kind 0=B,1=JAL,2=JALR,3=other.
    int f_kind;
    int f_off;

    function automatic logic [31:0] enc(input int kind, input int off);
        logic [31:0] o;
        o = off;
        case (kind)
            0: return {o[12], o[10:5], 13'd0, o[4:1], o[11], 7'b1100011};
            1: return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
            2: return {12'd0, 5'd1, 3'd0, 5'd1, 7'b1100111};
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_fetch(input bit v, input int kind, input logic [31:0] pc, input int off);
        if_valid = v; if_pc = pc; f_kind = kind; f_off = off; if_inst = enc(kind, off);
    endtask

    task automatic set_rob(input bit v, input bit jalr, input logic [31:0] pc, input bit tk,
                           input logic [31:0] tgt, input logic [7:0] gh, input bit mis);
        rob_valid = v; rob_is_jalr = jalr; rob_pc = pc; rob_taken = tk;
        rob_target = tgt; rob_ghr = gh; rob_mispredict = mis;
    endtask

    task automatic idle();
        set_fetch(0, 3, 32'h0, 0);
        set_rob(0, 0, 32'h0, 0, 32'h0, 8'h0, 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 256; i++) mpht[i] = 1;
        for (int i = 0; i < 16; i++) mbv[i] = 0;
        mghr = 0;
    endtask

    task automatic model_pred(output bit t, output logic [31:0] tg);
        int i, b;
        i = int'(((if_pc >> 2) & 32'hFF)) ^ mghr;
        b = int'((if_pc >> 2) & 32'hF);
        t = 0;
        tg = if_pc + 32'd4;
        if (if_valid) begin
            case (f_kind)
                0: if (mpht[i] >= 2) begin t = 1; tg = if_pc + f_off; end
                1: begin t = 1; tg = if_pc + f_off; end
                2: begin
`ifdef PREDICTOR_BTB_EN
                    if (mbv[b] && (mbpc[b] >> 6) == (if_pc >> 6)) begin t = 1; tg = mbtgt[b]; end
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_check();
        bit t;
        logic [31:0] tg;
        model_pred(t, tg);
        chk("model pred_taken", {31'd0, pred_taken}, {31'd0, t});
        chk("model pred_target", pred_target, tg);
        chk("model pred_ghr", {24'd0, pred_ghr}, mghr);
    endtask

    // Applies one clock edge's worth of behaviour to the model.
    task automatic model_commit();
        bit t;
        logic [31:0] tg;
        int ti;
        if (rst) begin
            reset_model();
        end else if (rdy) begin
            model_pred(t, tg);
            if (rob_valid && !rob_is_jalr) begin
                ti = int'(((rob_pc >> 2) & 32'hFF)) ^ int'(rob_ghr);
                if (rob_taken) mpht[ti] = (mpht[ti] == 3) ? 3 : mpht[ti] + 1;
                else           mpht[ti] = (mpht[ti] == 0) ? 0 : mpht[ti] - 1;
            end
            if (rob_valid && rob_is_jalr) begin
                ti = int'((rob_pc >> 2) & 32'hF);
                mbv[ti] = 1; mbpc[ti] = rob_pc; mbtgt[ti] = rob_target;
            end
            if (rob_valid && rob_mispredict)
                mghr = rob_is_jalr ? int'(rob_ghr) : ((int'(rob_ghr) * 2 + int'(rob_taken)) % 256);
            else if (if_valid && f_kind == 0)
                mghr = (mghr * 2 + int'(t)) % 256;
        end
    endtask

    task automatic fin();
        #1;
        model_check();
        model_commit();
        @(negedge clk);
        idle();
    endtask

    task automatic zero_ghr();
        set_rob(1, 1, 32'h0, 0, 32'h0, 8'h00, 1);
        fin();
    endtask

    typedef struct {
        bit          v;
        int          kind;
        logic [31:0] pc;
        int          off;
        bit          et;
        logic [31:0] etg;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 0, 32'h100, 16, 0, 32'h104};
        tbl[1] = '{1, 1, 32'h200, -8, 1, 32'h1F8};
        tbl[2] = '{1, 2, 32'h300, 0, 0, 32'h304};
        tbl[3] = '{1, 3, 32'h400, 0, 0, 32'h404};
        tbl[4] = '{0, 1, 32'h500, -8, 0, 32'h504};
        tbl[5] = '{1, 0, 32'h0, -4, 0, 32'h4};
        tbl[6] = '{1, 1, 32'hFFFFFFFC, 8, 1, 32'h4};

        rst = 1; rdy = 1; idle(); reset_model();
        repeat (2) @(negedge clk);
        rst = 0;
        #1 chk("reset ghr", {24'd0, pred_ghr}, 32'h0);

        // Vector table with rdy low so nothing moves between entries.
        rdy = 0;
        for (int i = 0; i < 7; i++) begin
            set_fetch(tbl[i].v, tbl[i].kind, tbl[i].pc, tbl[i].off);
            #1;
            chk($sformatf("vec%0d taken", i), {31'd0, pred_taken}, {31'd0, tbl[i].et});
            chk($sformatf("vec%0d target", i), pred_target, tbl[i].etg);
            chk($sformatf("vec%0d ghr", i), {24'd0, pred_ghr}, 32'h0);
        end
        @(negedge clk); idle();

        // Frozen: training and a fetch shift must both be ignored.
        set_fetch(1, 0, 32'h100, 16); set_rob(1, 0, 32'h100, 1, 0, 8'h0, 1); fin();
        set_fetch(1, 0, 32'h100, 16); set_rob(1, 0, 32'h100, 1, 0, 8'h0, 1); fin();
        rdy = 1;
        set_fetch(1, 0, 32'h100, 16);
        #1 chk("freeze taken", {31'd0, pred_taken}, 32'h0);
        chk("freeze ghr", {24'd0, pred_ghr}, 32'h0);
        if_valid = 0; fin();

        // Two taken trainings then predict taken.
        set_rob(1, 0, 32'h100, 1, 0, 8'h0, 0); fin();
        set_rob(1, 0, 32'h100, 1, 0, 8'h0, 0); fin();
        zero_ghr();
        set_fetch(1, 0, 32'h100, 16);
        #1 chk("trained taken", {31'd0, pred_taken}, 32'h1);
        chk("trained target", pred_target, 32'h110);
        if_valid = 0; fin();

        // Saturation: 4 taken then NT steps, reading old value each cycle.
        for (int i = 0; i < 4; i++) begin set_rob(1, 0, 32'h180, 1, 0, 8'h0, 0); fin(); end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_rob(1, 0, 32'h180, 0, 0, 8'h0, 0);
            set_fetch(1, 0, 32'h180, 8);
            #1 chk($sformatf("decay%0d taken", i), {31'd0, pred_taken}, (i < 2) ? 32'h1 : 32'h0);
            if_valid = 0; fin();
        end

        // Repair beats same-cycle speculative shift.
        zero_ghr();
        set_fetch(1, 0, 32'h100, 16); set_rob(1, 0, 32'h800, 0, 0, 8'h05, 1);
        #1 chk("collide pred taken", {31'd0, pred_taken}, 32'h1);
        fin();
        #1 chk("repair ghr", {24'd0, pred_ghr}, 32'h0A);
        zero_ghr();
        set_fetch(1, 0, 32'h100, 16); fin();
        #1 chk("shift ghr", {24'd0, pred_ghr}, 32'h01);

        // JAL does not touch history.
        set_fetch(1, 1, 32'h200, -8);
        #1 chk("jal taken", {31'd0, pred_taken}, 32'h1);
        chk("jal target", pred_target, 32'h1F8);
        fin();
        #1 chk("jal ghr", {24'd0, pred_ghr}, 32'h01);

        // JALR via BTB (or always sequential without it).
        set_rob(1, 1, 32'h300, 1, 32'h1000, 8'h01, 0); fin();
        set_fetch(1, 2, 32'h300, 0);
`ifdef PREDICTOR_BTB_EN
        #1 chk("jalr hit taken", {31'd0, pred_taken}, 32'h1);
        chk("jalr hit target", pred_target, 32'h1000);
`else
        #1 chk("jalr taken", {31'd0, pred_taken}, 32'h0);
        chk("jalr target", pred_target, 32'h304);
`endif
        fin();
        set_fetch(1, 2, 32'h340, 0);
        #1 chk("jalr alias taken", {31'd0, pred_taken}, 32'h0);
        chk("jalr alias target", pred_target, 32'h344);
        fin();

        // Reset mid-operation (rdy low) discards training and history.
        rst = 1; rdy = 0; fin();
        rst = 0; rdy = 1;
        set_fetch(1, 0, 32'h100, 16);
        #1 chk("post-reset taken", {31'd0, pred_taken}, 32'h0);
        chk("post-reset target", pred_target, 32'h104);
        chk("post-reset ghr", {24'd0, pred_ghr}, 32'h0);
        if_valid = 0; fin();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int k, off;
            k = int'($urandom_range(0, 3));
            off = (k == 1) ? int'($urandom_range(0, 1048575)) * 2 - 1048576
                           : int'($urandom_range(0, 4095)) * 2 - 4096;
            set_fetch($urandom_range(0, 3) != 0, k, 32'($urandom_range(0, 255)) << 2, off);
            set_rob($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    32'($urandom_range(0, 255)) << 2, $urandom_range(0, 1) == 1,
                    $urandom & 32'hFFFFFFFC, 8'($urandom), $urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
            fin();
        end
        rst = 0; rdy = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised gshare direction predictor, with an optional branch target buffer (BTB), sitting between the instruction fetcher and the reorder buffer. Fetch presents each instruction and PC and receives a same-cycle taken/target prediction plus a global-history snapshot that travels with the instruction. The ROB returns the resolved outcome at commit. That outcome trains a table of saturating counters indexed by PC XOR global history, and repairs the speculative history register on a mispredict.

## Interface
- `ADDR_W`, 32, address width
- `INST_W`, 32, instruction width
- `PHT_IDX_W`, 8, log2 of pattern-history-table entries
- `CTR_W`, 2, saturating counter width (≥2)
- `GHR_W`, 8, global history length (1..PHT_IDX_W)
- `BTB_IDX_W`, 4, log2 of BTB entries (used only with `PREDICTOR_BTB_EN`)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global enable; when low, all state is frozen
- `if_valid`  in  1  fetch presents an instruction this cycle
- `if_inst`  in  INST_W  fetched instruction
- `if_pc`  in  ADDR_W  PC of fetched instruction
- `pred_taken`  out  1  predicted redirect
- `pred_target`  out  ADDR_W  predicted next PC
- `pred_ghr`  out  GHR_W  history snapshot before this instruction's own update
- `rob_valid`  in  1  resolved control instruction committed
- `rob_is_jalr`  in  1  committed instruction is JALR (else conditional branch)
- `rob_pc`  in  ADDR_W  its PC
- `rob_taken`  in  1  actual direction
- `rob_target`  in  ADDR_W  actual target
- `rob_ghr`  in  GHR_W  snapshot captured at fetch
- `rob_mispredict`  in  1  direction or target was wrong

## Operation
- Lookup (combinational):
  - `idx = if_pc[PHT_IDX_W+1:2] ^ zero_ext(ghr)`.
  - `pred_ghr = ghr`.
- JAL: taken; target = `if_pc + immJ`.
- B-type: taken = MSB of `pht[idx]`; target = `if_pc + immB` if taken, else `if_pc + 4`.
- JALR: taken on BTB hit, target = BTB entry; on miss, not taken, target = `if_pc + 4`.
- Any other opcode, or `if_valid` low: `pred_taken = 0`, `pred_target = if_pc + 4`.
- Immediates are sign-extended to ADDR_W; the addition wraps modulo 2^ADDR_W.
- Speculative history: with `if_valid` and B-type, `ghr <= {ghr[GHR_W-2:0], pred_taken}`. JAL/JALR do not shift the history.
- Training, when `rob_valid` and not `rob_is_jalr`:
  - Index = `rob_pc[PHT_IDX_W+1:2] ^ zero_ext(rob_ghr)`.
  - Counter increments if `rob_taken`, else decrements, saturating at 0 and 2^CTR_W−1.
- Repair on `rob_valid && rob_mispredict`:
  - Branch: `ghr <= {rob_ghr[GHR_W-2:0], rob_taken}`.
  - JALR: `ghr <= rob_ghr`.
  - Repair overrides a same-cycle fetch shift.
- Reset: every counter = 2^(CTR_W−1)−1 (weakly not taken, 01 for CTR_W=2); `ghr = 0`; all BTB valid bits cleared.
- `rst` has priority over `rdy`; a reset mid-operation discards the history and all training.

## Timing
- Prediction latency 0 cycles: outputs are combinational from `if_*` and current state.
- Counter, GHR and BTB updates take effect at the next rising edge.
- A same-cycle read and write of one PHT entry: the read returns the old value (no bypass).
- One ROB update per cycle; `rob_valid` is a single-cycle pulse per committed instruction.
- `rdy` low: no state changes; combinational outputs still track the inputs.

## Configuration
- `PREDICTOR_BTB_EN` defined:
  - Direct-mapped BTB of 2^BTB_IDX_W entries {valid, tag = `pc[ADDR_W-1:BTB_IDX_W+2]`, target}.
  - Written on every `rob_valid && rob_is_jalr` with `rob_target`.
  - Lookup hits on valid && tag match.
- `PREDICTOR_BTB_EN` undefined: no BTB storage; JALR is always predicted not taken, target `if_pc + 4`.

## Structure
- Package `predictor_pkg`:
  - Opcode constants (JAL, JALR, BRANCH).
  - Immediate-extraction functions for J and B formats.
  - Counter saturating-update function.
- Sub-module `pred_btb`: tag/valid/target arrays with a read port and a write port, instantiated under the macro.
- PHT and GHR stay in the top module.

## Test plan
- After reset, B-type at `0x100`, offset +16, ghr=0 → `pred_taken=0`, `pred_target=0x104`, `pred_ghr=0`.
- Two ROB taken updates for pc `0x100`, `rob_ghr=0`, then fetch `0x100` with ghr forced 0 via a mispredict repair → `pred_taken=1`, target `0x110`.
- Four ROB taken updates on one entry, then three not-taken → counter 3→2→1→0; prediction flips to not taken after the second not-taken.
- Fetch branch predicted taken (ghr `0x00`→`0x01`) in the same cycle as a ROB mispredict with `rob_ghr=0x05`, `rob_taken=0` → next-cycle ghr = `0x0A`.
- JAL at `0x200`, imm −8 → `pred_taken=1`, `pred_target=0x1F8`, ghr unchanged.
- With the macro: ROB JALR pc `0x300`, target `0x1000`; next-cycle fetch JALR `0x300` → taken, target `0x1000`. Fetch JALR `0x340` (index collision, tag mismatch) → not taken, target `0x344`.
